bank_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer for one shared-memory bank. It picks one of NUM_REQ core

---
 rtl/bank_arbiter_pkg.sv | 19 +
 rtl/bank_arbiter_rr_pick.sv | 36 +++
 rtl/bank_arbiter.sv | 166 ++++++++++++++++
 tb/tb_bank_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/bank_arbiter_pkg.sv
// Shared sizes and FSM encodings for the bank arbiter slice.
// The per-core widths default the top-level parameters.
package bank_arbiter_pkg;

  localparam int NUM_OF_CORES   = 4;
  localparam int CORE_ID_SIZE   = 2;
  localparam int BANK_ADDR_SIZE = 8;
  localparam int BANK_REG_SIZE  = 8;
  localparam int DEF_MAX_BURST  = 4;

  // Wide enough for the largest legal burst length (15)
  localparam int BURST_CNT_W    = 4;

  typedef enum logic [0:0] {
    ARB_ST_ARB  = 1'b0,
    ARB_ST_LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/bank_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of mask searching upward from ptr+1.
// low_en substitutes low_idx for ptr so that low_idx becomes the lowest-priority core.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] mask,
  input  logic [ID_W-1:0]    ptr,
  input  logic               low_en,
  input  logic [ID_W-1:0]    low_idx,
  output logic               valid,
  output logic [ID_W-1:0]    idx,
  output logic [NUM_REQ-1:0] onehot
);

  logic [ID_W-1:0] w_base;
  logic [ID_W-1:0] w_cand;

  assign w_base = low_en ? low_idx : ptr;

  always_comb begin
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    w_cand = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = ID_W'((int'(w_base) + k) % NUM_REQ);
      if (!valid && mask[w_cand]) begin
        valid          = 1'b1;
        idx            = w_cand;
        onehot[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bank_arbiter.sv
// Round-robin arbiter and sequencer for one shared-memory bank with short locked bursts.
// Grants are combinational; ready and read data return to the winner one cycle later.
module bank_arbiter
  import bank_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = NUM_OF_CORES,
  parameter int ID_W      = CORE_ID_SIZE,
  parameter int ADDR_W    = BANK_ADDR_SIZE,
  parameter int DATA_W    = BANK_REG_SIZE,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_rd,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ-1:0]        req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [ADDR_W-1:0]         bank_addr,
  output logic [DATA_W-1:0]         bank_wdata,
  output logic                      bank_re,
  output logic                      bank_we,
  input  logic [DATA_W-1:0]         bank_rdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        ready,
  output logic [NUM_REQ*DATA_W-1:0] rd_data
);

  arb_state_e             r_state;
  arb_state_e             w_state_nxt;
  logic [ID_W-1:0]        r_ptr;
  logic [ID_W-1:0]        r_owner;
  logic [BURST_CNT_W-1:0] r_burst_cnt;
  logic [BURST_CNT_W-1:0] w_burst_nxt;
  logic [NUM_REQ-1:0]     r_wr_mask;

  logic [NUM_REQ-1:0]     r_gnt_q;
  logic [ID_W-1:0]        r_id_q;
  logic                   r_rd_q;

  logic [NUM_REQ-1:0]     w_elig;
  logic                   w_own_cont;
  logic                   w_lock_exit;
  logic                   w_pick_vld;
  logic [ID_W-1:0]        w_pick_idx;
  logic [NUM_REQ-1:0]     w_pick_onehot;

  logic                   w_win_vld;
  logic [ID_W-1:0]        w_win_idx;
  logic [NUM_REQ-1:0]     w_win_onehot;
  logic                   w_win_wr;
  logic                   w_win_rd;
  logic                   w_enter_lock;

  // A core that just had a write granted sits out one cycle while it samples ready
  assign w_elig = (req_rd | req_wr) & ~r_wr_mask;

  assign w_own_cont  = (r_state == ARB_ST_LOCK) && w_elig[r_owner] && req_lock[r_owner] &&
                       (r_burst_cnt < BURST_CNT_W'(MAX_BURST));
  assign w_lock_exit = (r_state == ARB_ST_LOCK) && !w_own_cont;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .mask    (w_elig),
    .ptr     (r_ptr),
    .low_en  (w_lock_exit),
    .low_idx (r_owner),
    .valid   (w_pick_vld),
    .idx     (w_pick_idx),
    .onehot  (w_pick_onehot)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ARB_ST_ARB;
      r_burst_cnt <= '0;
      r_owner     <= '0;
      r_ptr       <= ID_W'(NUM_REQ - 1);
    end else begin
      r_state     <= w_state_nxt;
      r_burst_cnt <= w_burst_nxt;
      if (w_enter_lock) begin
        r_owner <= w_win_idx;
      end
      if (w_win_vld) begin
        r_ptr <= w_win_idx;
      end
    end
  end

  // FSM next state; a forced or voluntary exit may immediately re-lock to a new winner
  always_comb begin
    w_state_nxt = ARB_ST_ARB;
    w_burst_nxt = '0;
    if (w_own_cont) begin
      w_state_nxt = ARB_ST_LOCK;
      w_burst_nxt = r_burst_cnt + 1'b1;
    end else if (w_enter_lock) begin
      w_state_nxt = ARB_ST_LOCK;
      w_burst_nxt = BURST_CNT_W'(1);
    end
  end

  // FSM outputs: winner selection, blanked while reset is high
  always_comb begin
    w_win_vld    = 1'b0;
    w_win_idx    = '0;
    w_win_onehot = '0;
    if (!reset) begin
      if (w_own_cont) begin
        w_win_vld             = 1'b1;
        w_win_idx             = r_owner;
        w_win_onehot[r_owner] = 1'b1;
      end else if (w_pick_vld) begin
        w_win_vld    = 1'b1;
        w_win_idx    = w_pick_idx;
        w_win_onehot = w_pick_onehot;
      end
    end
  end

  assign w_win_wr     = w_win_vld & req_wr[w_win_idx];
  assign w_win_rd     = w_win_vld & req_rd[w_win_idx] & ~req_wr[w_win_idx];
  assign w_enter_lock = w_win_vld && req_lock[w_win_idx] && (MAX_BURST > 1);

  assign gnt     = w_win_onehot;
  assign bank_we = w_win_wr;
  assign bank_re = w_win_rd;

  always_comb begin
    bank_addr  = '0;
    bank_wdata = '0;
    if (w_win_vld) begin
      bank_addr  = req_addr[w_win_idx*ADDR_W +: ADDR_W];
      bank_wdata = req_wdata[w_win_idx*DATA_W +: DATA_W];
    end
  end

  // Response stage: one cycle behind the grant, aligned with bank_rdata
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_mask <= '0;
      r_gnt_q   <= '0;
      r_id_q    <= '0;
      r_rd_q    <= 1'b0;
    end else begin
      r_wr_mask <= w_win_wr ? w_win_onehot : '0;
      r_gnt_q   <= w_win_onehot;
      r_id_q    <= w_win_idx;
      r_rd_q    <= w_win_rd;
    end
  end

  assign ready = r_gnt_q;

  always_comb begin
    rd_data = '0;
    if (r_rd_q) begin
      rd_data[r_id_q*DATA_W +: DATA_W] = bank_rdata;
    end
  end

endmodule

// File: tb/tb_bank_arbiter.sv
// Scoreboard bench for bank_arbiter: grants and bank fields are checked in the grant cycle,
// ready and rd_data are queued at grant time and compared one cycle later.
module tb_bank_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_rd, req_wr, req_lock;
  logic [31:0] req_addr, req_wdata;
  logic [7:0]  bank_addr, bank_wdata, bank_rdata;
  logic        bank_re, bank_we;
  logic [3:0]  gnt, ready;
  logic [31:0] rd_data;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] core_addr [4];
  logic [7:0] core_wdata[4];
  logic [7:0] bank_mem  [256];
  logic [7:0] exp_mem   [256];

  typedef struct {
    logic [3:0]  rdy;
    logic [31:0] data;
  } resp_t;

  resp_t sb[$];
  resp_t mon_r;

  always #5 clk = ~clk;

  bank_arbiter #(
    .NUM_REQ   (4),
    .ID_W      (2),
    .ADDR_W    (8),
    .DATA_W    (8),
    .MAX_BURST (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_rd     (req_rd),
    .req_wr     (req_wr),
    .req_lock   (req_lock),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .bank_addr  (bank_addr),
    .bank_wdata (bank_wdata),
    .bank_re    (bank_re),
    .bank_we    (bank_we),
    .bank_rdata (bank_rdata),
    .gnt        (gnt),
    .ready      (ready),
    .rd_data    (rd_data)
  );

  // Bank macro model: read data valid the cycle after bank_re
  always @(posedge clk) begin
    if (bank_we) bank_mem[bank_addr] <= bank_wdata;
    if (bank_re) bank_rdata <= bank_mem[bank_addr];
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic apply_fields();
    for (int i = 0; i < 4; i++) begin
      req_addr[i*8 +: 8]  = core_addr[i];
      req_wdata[i*8 +: 8] = core_wdata[i];
    end
  endtask

  task automatic step(input logic [3:0] rd, input logic [3:0] wr, input logic [3:0] lock,
                      input logic [3:0] exp_gnt, input string tag);
    int         w;
    logic       e_we, e_re;
    logic [7:0] e_addr, e_wdata;
    resp_t      r;
    @(negedge clk);
    req_rd   = rd;
    req_wr   = wr;
    req_lock = lock;
    #1;
    w       = -1;
    e_we    = 1'b0;
    e_re    = 1'b0;
    e_addr  = 8'h00;
    e_wdata = 8'h00;
    r.rdy   = exp_gnt;
    r.data  = 32'h0;
    for (int i = 0; i < 4; i++) if (exp_gnt[i]) w = i;
    if (w >= 0) begin
      e_we    = wr[w];
      e_re    = rd[w] & ~wr[w];
      e_addr  = core_addr[w];
      e_wdata = core_wdata[w];
      if (e_we) exp_mem[e_addr] = e_wdata;
      if (e_re) r.data[w*8 +: 8] = exp_mem[e_addr];
    end
    chk({tag, ".gnt"},   32'(gnt),        32'(exp_gnt));
    chk({tag, ".we"},    32'(bank_we),    32'(e_we));
    chk({tag, ".re"},    32'(bank_re),    32'(e_re));
    chk({tag, ".addr"},  32'(bank_addr),  32'(e_addr));
    chk({tag, ".wdata"}, 32'(bank_wdata), 32'(e_wdata));
    sb.push_back(r);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_r = sb.pop_front();
      chk("resp.ready",   32'(ready), 32'(mon_r.rdy));
      chk("resp.rd_data", rd_data,    mon_r.data);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int a = 0; a < 256; a++) begin
      bank_mem[a] = 8'(a) ^ 8'h5A;
      exp_mem[a]  = 8'(a) ^ 8'h5A;
    end
    core_addr  = '{8'h20, 8'h21, 8'h22, 8'h23};
    core_wdata = '{8'hC0, 8'hC1, 8'hC2, 8'hC3};
    reset      = 1'b1;
    req_rd     = 4'b0;
    req_wr     = 4'b0;
    req_lock   = 4'b0;
    bank_rdata = 8'h00;
    apply_fields();

    // Reset state, with requests present
    #2;
    chk("rst.ready",   32'(ready), 32'h0);
    chk("rst.rd_data", rd_data,    32'h0);
    req_rd   = 4'b1111;
    req_lock = 4'b1111;
    #1;
    chk("rst.gnt", 32'(gnt),     32'h0);
    chk("rst.re",  32'(bank_re), 32'h0);
    @(negedge clk);
    req_rd   = 4'b0;
    req_lock = 4'b0;
    reset    = 1'b0;

    // All cores read every cycle
    step(4'b1111, 4'b0, 4'b0, 4'b0001, "rr0");
    step(4'b1111, 4'b0, 4'b0, 4'b0010, "rr1");
    step(4'b1111, 4'b0, 4'b0, 4'b0100, "rr2");
    step(4'b1111, 4'b0, 4'b0, 4'b1000, "rr3");
    step(4'b1111, 4'b0, 4'b0, 4'b0001, "rr4");
    step(4'b0,    4'b0, 4'b0, 4'b0000, "rr_idle");

    // Held write from core 2 is de-duplicated
    core_addr[2]  = 8'h10;
    core_wdata[2] = 8'hA5;
    apply_fields();
    step(4'b0, 4'b0100, 4'b0, 4'b0100, "wr0");
    step(4'b0, 4'b0100, 4'b0, 4'b0000, "wr1");
    step(4'b0, 4'b0100, 4'b0, 4'b0100, "wr2");
    step(4'b0, 4'b0,    4'b0, 4'b0000, "wr_idle");
    core_addr[2]  = 8'h22;
    core_wdata[2] = 8'hC2;
    apply_fields();

    // Idle cycles keep the pointer at core 2
    for (int i = 0; i < 4; i++) step(4'b0, 4'b0, 4'b0, 4'b0000, "hold_idle");
    step(4'b1001, 4'b0, 4'b0, 4'b1000, "hold_a");
    step(4'b1001, 4'b0, 4'b0, 4'b0001, "hold_b");
    step(4'b0,    4'b0, 4'b0, 4'b0000, "hold_end");

    // Locked burst from core 1, bounded at four grants
    for (int i = 0; i < 4; i++) step(4'b1011, 4'b0, 4'b0010, 4'b0010, "lk_burst");
    step(4'b1011, 4'b0, 4'b0010, 4'b1000, "lk_x3");
    step(4'b1011, 4'b0, 4'b0010, 4'b0001, "lk_x0");
    step(4'b1011, 4'b0, 4'b0010, 4'b0010, "lk_re1");
    step(4'b0,    4'b0, 4'b0,    4'b0000, "lk_idle");

    // Read and write together from core 2 is a write
    step(4'b0100, 4'b0100, 4'b0, 4'b0100, "rdwr");
    step(4'b0,    4'b0,    4'b0, 4'b0000, "rdwr_idle");

    // Reset during a locked burst at burst_cnt 2
    step(4'b0010, 4'b0, 4'b0010, 4'b0010, "rl1");
    step(4'b0010, 4'b0, 4'b0010, 4'b0010, "rl2");
    @(negedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    #1;
    chk("rl.gnt",     32'(gnt),     32'h0);
    chk("rl.ready",   32'(ready),   32'h0);
    chk("rl.rd_data", rd_data,      32'h0);
    chk("rl.re",      32'(bank_re), 32'h0);
    chk("rl.addr",    32'(bank_addr), 32'h0);
    repeat (2) @(negedge clk);
    reset    = 1'b0;
    req_rd   = 4'b0;
    req_lock = 4'b0;
    step(4'b1001, 4'b0, 4'b0, 4'b0001, "post_rst");
    step(4'b0,    4'b0, 4'b0, 4'b0000, "post_idle");
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
